// File: rtl/arp_reply_sched.sv
// -----------------------------------------------------------------------------
// arp_reply_sched
//
// Queues ARP reply requests coming from the ARP request detector. Each request
// carries the requester MAC/IP. The block hands the requests one at a time to
// the byte-serial reply transmitter. After every reply it holds an inter-frame
// gap, and it aborts a reply whose completion never arrives.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   areset       synchronous, active-high reset
//   req_valid    one-cycle request pulse from the detector
//   req_mac      requester MAC, captured with req_valid
//   req_ip       requester IP, captured with req_valid
//   tx_done      one-cycle pulse from the transmitter: last reply byte sent
//   tx_start     one-cycle pulse: transmitter begins a reply
//   tx_dest_mac  destination MAC of the current/last reply (held between pops)
//   tx_dest_ip   destination IP of the current/last reply (held between pops)
//   busy         high whenever the sequencer is not idle
//   fifo_level   number of queued requests, 0..DEPTH
//   drop_cnt     requests lost to a full queue, saturating at 255
//   timeout_err  one-cycle pulse when the completion watchdog expires
// -----------------------------------------------------------------------------
module arp_reply_sched #(
  parameter int DEPTH          = 4,     // queue entries, power of 2, 2..16
  parameter int GAP_CYCLES     = 12,    // idle clocks after each reply, >= 1
  parameter int TIMEOUT_CYCLES = 1024   // clocks allowed for tx_done, >= 2
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   req_valid,
  input  logic [47:0]            req_mac,
  input  logic [31:0]            req_ip,
  input  logic                   tx_done,
  output logic                   tx_start,
  output logic [47:0]            tx_dest_mac,
  output logic [31:0]            tx_dest_ip,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             drop_cnt,
  output logic                   timeout_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  typedef struct packed {
    logic [47:0] mac;
    logic [31:0] ip;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [1:0]       state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  entry_t           dest_q, dest_d;
  logic             idle_settled_q, idle_settled_d;

  logic             fifo_full;
  logic             fifo_pop;
  logic             fifo_push;
  logic             req_drop;
  logic             timeout_hit;

  // ---------------------------------------------------------------------------
  // Queue control
  // ---------------------------------------------------------------------------
  // The first IDLE cycle after a gap never pops. Busy still drops
  // GAP_CYCLES+1 clocks after tx_done, while a queued reply starts no earlier
  // than GAP_CYCLES+3 clocks after it. A request arriving into a long-idle
  // scheduler still starts two clocks later.
  assign fifo_full = (level_q == LVL_FULL);
  assign fifo_pop  = (state_q == ST_IDLE) && idle_settled_q && (level_q != '0);
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign fifo_push = req_valid && (!fifo_full || fifo_pop);
  assign req_drop  = req_valid && fifo_full && !fifo_pop;

  always_comb begin
    // NOTE: each always_comb assigns a default to every output before any branch, so no path can infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    dest_d     = dest_q;

    if (fifo_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      dest_d   = mem_q[rd_ptr_q];
    end

    // Push and pop together leave the level unchanged.
    unique case ({fifo_push, fifo_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (req_drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    wd_d           = wd_q;
    gap_d          = gap_q;
    timeout_hit    = 1'b0;
    idle_settled_d = (state_q == ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (fifo_pop) state_d = ST_START;
      end
      ST_START: begin
        wd_d    = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // tx_done wins over an expiring watchdog in the same cycle.
        if (tx_done) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end else if (wd_q == WD_LAST) begin
          timeout_hit = 1'b1;
          state_d     = ST_GAP;
          gap_d       = '0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (areset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      drop_cnt_q     <= '0;
      state_q        <= ST_IDLE;
      wd_q           <= '0;
      gap_q          <= '0;
      dest_q         <= '0;
      idle_settled_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      drop_cnt_q     <= drop_cnt_d;
      state_q        <= state_d;
      wd_q           <= wd_d;
      gap_q          <= gap_d;
      dest_q         <= dest_d;
      idle_settled_q <= idle_settled_d;
    end
  end

  // NOTE: queue storage has no reset; an entry is only read after it was written, guarded by level_q.
  always_ff @(posedge clk) begin
    if (!areset && fifo_push) mem_q[wr_ptr_q] <= '{mac: req_mac, ip: req_ip};
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tx_start    = (state_q == ST_START);
  assign busy        = (state_q != ST_IDLE);
  assign tx_dest_mac = dest_q.mac;
  assign tx_dest_ip  = dest_q.ip;
  assign fifo_level  = level_q;
  assign drop_cnt    = drop_cnt_q;
  assign timeout_err = timeout_hit;

endmodule

// File: tb/tb_arp_reply_sched.sv
// -----------------------------------------------------------------------------
// tb_arp_reply_sched
//
// Self-checking bench for arp_reply_sched. A timestamp-based reference model
// (request queue plus frame start/end times) predicts every output each cycle.
// A vector table covers the single-request timeline. Hand-written sequences
// cover overflow, push-on-pop, watchdog, reset and drop saturation, and a
// randomized phase closes out the run.
// -----------------------------------------------------------------------------
module tb_arp_reply_sched;

  localparam int DEPTH = 4;
  localparam int GAP   = 12;
  localparam int TOUT  = 1024;

  logic        clk = 1'b0;
  logic        areset;
  logic        req_valid;
  logic [47:0] req_mac;
  logic [31:0] req_ip;
  logic        tx_done;
  logic        tx_start;
  logic [47:0] tx_dest_mac;
  logic [31:0] tx_dest_ip;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_cnt;
  logic        timeout_err;

  arp_reply_sched #(
    .DEPTH          (DEPTH),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk         (clk),
    .areset      (areset),
    .req_valid   (req_valid),
    .req_mac     (req_mac),
    .req_ip      (req_ip),
    .tx_done     (tx_done),
    .tx_start    (tx_start),
    .tx_dest_mac (tx_dest_mac),
    .tx_dest_ip  (tx_dest_ip),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .drop_cnt    (drop_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Outputs observed in the most recent stepped cycle.
  int          obs_cyc;
  logic        obs_start, obs_busy, obs_tout;
  logic [2:0]  obs_lvl;
  logic [7:0]  obs_drop;
  logic [47:0] obs_mac;
  logic [31:0] obs_ip;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a request queue plus the cycle numbers of the current
  // frame's start and end. Frame rules: start one cycle after the pop, end on
  // tx_done or TOUT cycles after the start, idle GAP+1 cycles after the end,
  // and the next pop allowed GAP+2 cycles after the end.
  // ---------------------------------------------------------------------------
  logic [79:0] m_q[$];
  int          m_drop  = 0;
  logic [79:0] m_dest  = '0;
  bit          m_live  = 1'b0;
  int          m_start = 0;
  int          m_end   = -1;
  int          m_free  = 0;

  task automatic model_step(input logic rst, input logic rv, input logic [47:0] mac,
                            input logic [31:0] ip, input logic done, input int t,
                            output logic e_start, output logic e_busy, output logic e_tout,
                            output logic [2:0] e_lvl, output logic [7:0] e_drop,
                            output logic [79:0] e_dest);
    int sz0;
    bit pop;
    bit waiting;
    sz0 = m_q.size();
    if (m_live && m_end >= 0 && t >= m_end + GAP + 1) m_live = 1'b0;
    e_busy  = m_live && (t >= m_start);
    e_start = m_live && (t == m_start);
    waiting = m_live && (m_end < 0) && (t > m_start);
    e_tout  = waiting && !done && (t == m_start + TOUT);
    if (waiting && (done || e_tout)) begin
      m_end  = t;
      m_free = t + GAP + 2;
    end
    e_lvl  = 3'(sz0);
    e_drop = 8'(m_drop);
    e_dest = m_dest;
    if (rst) begin
      m_q.delete();
      m_drop = 0;
      m_dest = '0;
      m_live = 1'b0;
      m_free = t + 1;
    end else begin
      pop = !m_live && (t >= m_free) && (sz0 > 0);
      if (pop) begin
        m_dest  = m_q.pop_front();
        m_live  = 1'b1;
        m_start = t + 1;
        m_end   = -1;
      end
      if (rv) begin
        if (sz0 < DEPTH || pop) m_q.push_back({mac, ip});
        else if (m_drop < 255)  m_drop++;
      end
    end
  endtask

  // One clock cycle: drive inputs, sample outputs, compare to the model, clock.
  task automatic step(input logic rst, input logic rv, input logic [47:0] mac,
                      input logic [31:0] ip, input logic done);
    logic        e_start, e_busy, e_tout;
    logic [2:0]  e_lvl;
    logic [7:0]  e_drop;
    logic [79:0] e_dest;
    areset    = rst;
    req_valid = rv;
    req_mac   = mac;
    req_ip    = ip;
    tx_done   = done;
    #2;
    obs_cyc   = cyc;
    obs_start = tx_start;
    obs_busy  = busy;
    obs_tout  = timeout_err;
    obs_lvl   = fifo_level;
    obs_drop  = drop_cnt;
    obs_mac   = tx_dest_mac;
    obs_ip    = tx_dest_ip;
    model_step(rst, rv, mac, ip, done, cyc, e_start, e_busy, e_tout, e_lvl, e_drop, e_dest);
    check("model tx_start",    tx_start,    e_start);
    check("model busy",        busy,        e_busy);
    check("model timeout_err", timeout_err, e_tout);
    check("model fifo_level",  fifo_level,  e_lvl);
    check("model drop_cnt",    drop_cnt,    e_drop);
    check("model tx_dest",     {tx_dest_mac, tx_dest_ip}, e_dest);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 48'h0, 32'h0, 1'b0);
  endtask

  task automatic req(input logic [47:0] mac, input logic [31:0] ip);
    step(1'b0, 1'b1, mac, ip, 1'b0);
  endtask

  task automatic pulse_done();
    step(1'b0, 1'b0, 48'h0, 32'h0, 1'b1);
  endtask

  // Step until tx_start is seen; an expired budget counts as a failure.
  task automatic wait_start(input string name, output int at);
    int k;
    at = -1;
    k  = 0;
    while (at < 0 && k < 64) begin
      idle(1);
      if (obs_start) at = obs_cyc;
      k++;
    end
    if (at < 0) check(name, 1'b0, 1'b1);
  endtask

  task automatic drain(input int n);
    int s;
    for (int i = 0; i < n; i++) begin
      wait_start("drain tx_start wait", s);
      pulse_done();
    end
    idle(GAP + 3);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table for the single-request timeline (cycle 0 = first after reset)
  // ---------------------------------------------------------------------------
  typedef struct {
    int          reps;
    logic        rv;
    logic [47:0] mac;
    logic [31:0] ip;
    logic        done;
    logic        e_start;
    logic        e_busy;
    logic [2:0]  e_lvl;
    logic        e_tout;
    logic [7:0]  e_drop;
    logic [47:0] e_mac;
    logic [31:0] e_ip;
  } vec_t;

  localparam logic [47:0] MAC1 = 48'h001122334455;
  localparam logic [31:0] IP1  = 32'hC0A80105;

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL global time limit reached at cycle %0d", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [47:0] mlist[6];
    int s, s1, s2, dm, tcyc, tcnt, scnt;
    logic [7:0] drop_before;

    areset    = 1'b1;
    req_valid = 1'b0;
    req_mac   = '0;
    req_ip    = '0;
    tx_done   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    areset = 1'b0;

    // ---- single request: tx_start at 12, tx_done at 30, busy low at 43 ----
    tbl[0] = '{10, 1'b0, 48'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 48'h0, 32'h0};
    tbl[1] = '{ 1, 1'b1, MAC1,  IP1,   1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 48'h0, 32'h0};
    tbl[2] = '{ 1, 1'b0, 48'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 8'd0, 48'h0, 32'h0};
    tbl[3] = '{ 1, 1'b0, 48'h0, 32'h0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'd0, MAC1,  IP1};
    tbl[4] = '{17, 1'b0, 48'h0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'd0, MAC1,  IP1};
    tbl[5] = '{ 1, 1'b0, 48'h0, 32'h0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 8'd0, MAC1,  IP1};
    tbl[6] = '{12, 1'b0, 48'h0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'd0, MAC1,  IP1};
    tbl[7] = '{ 5, 1'b0, 48'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0, MAC1,  IP1};
    tbl[8] = '{ 2, 1'b0, 48'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0, MAC1,  IP1};

    for (int v = 0; v < 9; v++) begin
      for (int r = 0; r < tbl[v].reps; r++) begin
        step(1'b0, tbl[v].rv, tbl[v].mac, tbl[v].ip, tbl[v].done);
        check("vec tx_start",    obs_start, tbl[v].e_start);
        check("vec busy",        obs_busy,  tbl[v].e_busy);
        check("vec fifo_level",  obs_lvl,   tbl[v].e_lvl);
        check("vec timeout_err", obs_tout,  tbl[v].e_tout);
        check("vec drop_cnt",    obs_drop,  tbl[v].e_drop);
        check("vec tx_dest",     {obs_mac, obs_ip}, {tbl[v].e_mac, tbl[v].e_ip});
      end
    end

    // ---- five requests during WAIT_DONE: four queued, one dropped ----
    for (int i = 0; i < 6; i++) mlist[i] = 48'hA00000000000 + 48'(i);
    req(mlist[0], 32'h0A000000);
    wait_start("A first tx_start wait", s);
    idle(2);
    for (int i = 1; i < 6; i++) req(mlist[i], 32'h0A000000 + 32'(i));
    idle(1);
    check("A fifo_level full", obs_lvl, 3'd4);
    check("A drop_cnt one", obs_drop, 8'd1);
    for (int i = 1; i < 5; i++) begin
      pulse_done();
      dm = obs_cyc;
      wait_start("A queued tx_start wait", s);
      check("A spacing >= GAP+3", (s - dm) >= GAP + 3, 1'b1);
      check("A order mac", obs_mac, mlist[i]);
      check("A order ip", obs_ip, 32'h0A000000 + 32'(i));
    end
    pulse_done();
    idle(GAP + 3);

    // ---- full queue in IDLE, request lands on the pop cycle ----
    req(48'hB00000000000, 32'h0B000000);
    wait_start("B tx_start wait", s);
    for (int i = 1; i < 5; i++) req(48'hB00000000000 + 48'(i), 32'h0B000000 + 32'(i));
    idle(1);
    check("B fifo_level full", obs_lvl, 3'd4);
    drop_before = obs_drop;
    pulse_done();
    idle(GAP + 1);
    check("B idle before pop", obs_busy, 1'b0);
    req(48'hB00000000005, 32'h0B000005);
    check("B level on pop cycle", obs_lvl, 3'd4);
    idle(1);
    check("B tx_start after pop", obs_start, 1'b1);
    check("B level after push+pop", obs_lvl, 3'd4);
    check("B drop_cnt unchanged", obs_drop, drop_before);
    check("B head popped", obs_mac, 48'hB00000000001);
    pulse_done();
    drain(4);

    // ---- watchdog expiry, then tx_done exactly on the expiry cycle ----
    req(48'hC00000000000, 32'h0C000000);
    req(48'hC00000000001, 32'h0C000001);
    wait_start("C tx_start wait", s);
    tcnt = 0;
    tcyc = -1;
    for (int k = 0; k < TOUT + 2; k++) begin
      step(1'b0, k == 5, 48'hC00000000002, 32'h0C000002, 1'b0);
      if (obs_tout) begin
        tcnt++;
        tcyc = obs_cyc;
      end
    end
    check("C timeout pulse count", tcnt, 1);
    check("C timeout after WAIT entry", tcyc - (s + 1), TOUT - 1);
    wait_start("C next tx_start wait", s1);
    check("C next start spacing", s1 - tcyc, GAP + 3);
    check("C next entry mac", obs_mac, 48'hC00000000001);
    while (cyc < s1 + TOUT) idle(1);
    pulse_done();
    check("C done on expiry no timeout", obs_tout, 1'b0);
    check("C done on expiry busy", obs_busy, 1'b1);
    wait_start("C third tx_start wait", s2);
    check("C done on expiry spacing", s2 - (s1 + TOUT), GAP + 3);
    check("C third entry mac", obs_mac, 48'hC00000000002);
    pulse_done();
    idle(GAP + 3);

    // ---- reset during WAIT_DONE with three entries queued ----
    req(48'hD00000000000, 32'h0D000000);
    wait_start("D tx_start wait", s);
    for (int i = 1; i < 4; i++) req(48'hD00000000000 + 48'(i), 32'h0D000000 + 32'(i));
    idle(1);
    check("D fifo_level three", obs_lvl, 3'd3);
    step(1'b1, 1'b0, 48'h0, 32'h0, 1'b0);
    idle(1);
    check("D reset busy", obs_busy, 1'b0);
    check("D reset fifo_level", obs_lvl, 3'd0);
    check("D reset drop_cnt", obs_drop, 8'd0);
    check("D reset tx_dest", {obs_mac, obs_ip}, 80'h0);
    check("D reset tx_start", obs_start, 1'b0);
    check("D reset timeout_err", obs_tout, 1'b0);
    scnt = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b0, 48'h0, 32'h0, k == 3);
      if (obs_start) scnt++;
    end
    check("D no tx_start after reset", scnt, 0);
    req(48'hD00000000004, 32'h0D000004);
    idle(1);
    idle(1);
    check("D new request N+2", obs_start, 1'b1);
    check("D new request mac", obs_mac, 48'hD00000000004);

    // ---- 300 requests against a stalled transmitter ----
    for (int i = 0; i < 300; i++) req(48'hE00000000000 + 48'(i), 32'h0E000000 + 32'(i));
    idle(1);
    check("E drop_cnt saturated", obs_drop, 8'd255);
    check("E fifo_level full", obs_lvl, 3'd4);
    pulse_done();
    drain(4);
    check("E drop_cnt holds", obs_drop, 8'd255);

    // ---- randomized traffic against the model ----
    for (int k = 0; k < 4000; k++) begin
      logic rst_r, rv_r, done_r;
      rst_r  = ($urandom_range(999) == 0);
      rv_r   = ($urandom_range(3) == 0);
      done_r = ($urandom_range(5) == 0) && !((k % 2000) >= 500 && (k % 2000) < 1700);
      step(rst_r, rv_r, {16'($urandom()), $urandom()}, $urandom(), done_r);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/arp_reply_sched.md
Name: arp_reply_sched

Overview:
- Queues ARP reply requests raised by the input detector (arp_send pulse plus requester MAC/IP).
- Sequences the byte-serial ARP reply transmitter one frame at a time.
- Enforces an inter-frame gap and a watchdog on transmitter completion.
- Sits between the detector and the reply builder/MAC TX path.

Parameters:
- DEPTH, 4, request FIFO entries; power of 2, range 2..16.
- GAP_CYCLES, 12, idle clocks enforced after each reply (≥1).
- TIMEOUT_CYCLES, 1024, max clocks waiting for tx_done before abort (≥2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- req_valid  in  1  one-cycle request pulse (detector arp_send).
- req_mac  in  48  requester MAC, sampled when req_valid=1.
- req_ip  in  32  requester IP, sampled when req_valid=1.
- tx_done  in  1  one-cycle pulse from transmitter: last reply byte sent.
- tx_start  out  1  one-cycle pulse: transmitter begins a reply.
- tx_dest_mac  out  48  destination MAC for current reply.
- tx_dest_ip  out  32  destination IP for current reply.
- busy  out  1  high in any state other than IDLE.
- fifo_level  out  $clog2(DEPTH)+1  queued entries, 0..DEPTH.
- drop_cnt  out  8  requests dropped on full FIFO; saturates at 255.
- timeout_err  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset (sampled on clk edge only): state IDLE; FIFO emptied; all outputs 0. Reset mid-frame abandons the frame without a pulse.
- FIFO: circular, {mac,ip} per entry; wr/rd pointers wrap modulo DEPTH; level counter separate.
- Push: req_valid=1 and level<DEPTH, or level=DEPTH with a pop in the same cycle.
- Drop: req_valid=1 and level=DEPTH with no pop in the same cycle. drop_cnt increments on drop, holds at 255.
- Simultaneous push and pop: level unchanged; ordering preserved (pop returns the older head).
- FSM states IDLE, START, WAIT_DONE, GAP:
  - IDLE: if level>0, pop head into tx_dest_mac/tx_dest_ip and go to START; else stay.
  - START: tx_start=1 for exactly this cycle; clear watchdog; go to WAIT_DONE.
  - WAIT_DONE: on tx_done=1, go to GAP. Otherwise watchdog increments; when it reaches TIMEOUT_CYCLES-1 without tx_done, pulse timeout_err (same cycle) and go to GAP.
  - GAP: count GAP_CYCLES clocks, then go to IDLE.
- tx_done outside WAIT_DONE: ignored.
- tx_done in the same cycle the watchdog expires: counts as done; no timeout_err.
- tx_dest_mac/ip: updated only on pop; otherwise held, including through GAP and IDLE.
- Latency: req_valid in cycle N with FSM in IDLE and FIFO empty gives tx_start in cycle N+2.
- Back-to-back spacing: tx_done in cycle M gives the next tx_start no earlier than cycle M+GAP_CYCLES+3.
- busy=0 only in IDLE. fifo_level reflects the registered count.
- Duplicate requests are not merged; each accepted request produces exactly one tx_start.

Test Plan:
- Reset, then single request (mac=0x001122334455, ip=0xC0A80105) at cycle 10 -> tx_start at cycle 12 with matching tx_dest_*. tx_done at 30 -> busy falls at 43 (GAP 12), fifo_level returns to 0.
- Five requests on consecutive cycles while FSM is in WAIT_DONE, DEPTH=4 -> four queued, drop_cnt=1. Replies issued in arrival order, each tx_start separated by ≥GAP_CYCLES+3 from the prior tx_done.
- FIFO full in IDLE and req_valid in the pop cycle -> request accepted, fifo_level stays 4, drop_cnt unchanged.
- tx_done withheld -> timeout_err pulses once, 1023 cycles after the WAIT_DONE entry cycle, then GAP, then the next queued entry starts. tx_done on the expiry cycle -> no timeout_err.
- areset held for 1 cycle during WAIT_DONE with 3 entries queued -> next cycle all outputs 0, fifo_level=0. Later tx_done is ignored and no tx_start occurs until a new request.
- 300 requests against a stalled transmitter -> drop_cnt saturates at 255 and does not wrap.
